// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter
package mem_arb_pkg;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester and memory-side signals of the arbiter
interface mem_arbiter_if;
  logic        if_req;
  logic [15:0] if_addr;
  logic        dm_req;
  logic        dm_wr;
  logic [15:0] dm_addr;
  logic [15:0] dm_wdata;
  logic        m_req;
  logic        m_wr;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic        m_done;
  logic [15:0] m_rdata;
  logic        if_done;
  logic [15:0] if_rdata;
  logic        dm_done;
  logic [15:0] dm_rdata;
  logic        if_stall;
  logic        dm_stall;
  logic        err;
  modport slave (
    input  if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, m_done, m_rdata,
    output m_req, m_wr, m_addr, m_wdata, if_done, if_rdata, dm_done, dm_rdata,
           if_stall, dm_stall, err
  );
  modport master (
    output if_req, if_addr, dm_req, dm_wr, dm_addr, dm_wdata, m_done, m_rdata,
    input  m_req, m_wr, m_addr, m_wdata, if_done, if_rdata, dm_done, dm_rdata,
           if_stall, dm_stall, err
  );
endinterface

// File: rtl/arb_watchdog.sv
// arb_watchdog: clear/increment cycle counter that flags expiry at TIMEOUT
module arb_watchdog
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);
  logic [CNT_W-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= (rst | i_clr) ? '0 : i_inc ? r_cnt + CNT_W'(1) : r_cnt;
  assign o_expired = r_cnt == CNT_W'(TIMEOUT);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: alternating fetch/data arbiter for a shared single-port memory with timeout
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  state_t      r_state, w_next;
  owner_t      r_owner;
  logic        r_last_dm, r_wr, r_err;
  logic [15:0] r_addr, r_wdata, r_if_rdata, r_dm_rdata, w_cap;
  logic        w_grant_dm, w_start, w_fin, w_expired, w_clr, w_inc;
  // dm wins a tie unless it won the previous grant
  assign w_grant_dm = bus.dm_req & (~bus.if_req | ~r_last_dm);
  assign w_start    = r_state == IDLE & (bus.if_req | bus.dm_req);
  assign w_fin      = r_state == WAIT & (bus.m_done | w_expired);
  assign w_cap      = (bus.m_done & ~r_wr) ? bus.m_rdata : '0;
  assign w_clr      = r_state == ISSUE;
  assign w_inc      = r_state == WAIT & ~bus.m_done;
  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk), .rst(rst), .i_clr(w_clr), .i_inc(w_inc), .o_expired(w_expired)
  );
  always_ff @(posedge clk)
    r_state <= rst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = (bus.if_req | bus.dm_req) ? ISSUE : IDLE;
      ISSUE:   w_next = WAIT;
      WAIT:    w_next = (bus.m_done | w_expired) ? DONE : WAIT;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    bus.m_req   = r_state == ISSUE;
    bus.m_wr    = r_state == ISSUE & r_wr;
    bus.if_done = r_state == DONE & r_owner == OWN_IF;
    bus.dm_done = r_state == DONE & r_owner == OWN_DM;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner    <= OWN_IF;
      r_last_dm  <= 1'b0;
      r_addr     <= '0;
      r_wr       <= 1'b0;
      r_wdata    <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_start) begin
        r_owner   <= w_grant_dm ? OWN_DM : OWN_IF;
        r_last_dm <= w_grant_dm;
        r_addr    <= w_grant_dm ? bus.dm_addr : bus.if_addr;
        r_wr      <= w_grant_dm & bus.dm_wr;
        r_wdata   <= w_grant_dm ? bus.dm_wdata : '0;
      end
      if (w_fin) begin
        r_if_rdata <= r_owner == OWN_IF ? w_cap : r_if_rdata;
        r_dm_rdata <= r_owner == OWN_DM ? w_cap : r_dm_rdata;
        r_err      <= r_err | ~bus.m_done;
      end
    end
  end
  assign bus.m_addr   = r_addr;
  assign bus.m_wdata  = r_wdata;
  assign bus.if_rdata = r_if_rdata;
  assign bus.dm_rdata = r_dm_rdata;
  assign bus.err      = r_err;
  assign bus.if_stall = bus.if_req & ~bus.if_done;
  assign bus.dm_stall = bus.dm_req & ~bus.dm_done;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
  typedef struct {
    int          c;
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
  } mreq_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int mem_delay = 1;
  mreq_t mlog[$];
  logic [15:0] mem_arr [logic [15:0]];
  logic [15:0] ref_mem [logic [15:0]];
  logic last_dm, exp_err;
  logic [15:0] exp_if_rd, exp_dm_rd;
  mem_arbiter_if bus();
  mem_arbiter #(.TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // memory: logs every m_req cycle and answers mem_delay cycles later (0 = never)
  initial begin
    int cnt;
    logic p_wr;
    logic [15:0] p_addr;
    cnt = 0;
    p_wr = 1'b0;
    p_addr = '0;
    bus.m_done = 1'b0;
    bus.m_rdata = '0;
    mem_arr[16'h0010] = 16'h1234;
    forever begin
      @(posedge clk);
      #1;
      bus.m_done = 1'b0;
      bus.m_rdata = 16'($urandom);
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.m_done = 1'b1;
          if (!p_wr) bus.m_rdata = mem_arr.exists(p_addr) ? mem_arr[p_addr] : p_addr ^ 16'h5A5A;
        end
      end
      if (bus.m_req) begin
        mlog.push_back('{cyc, bus.m_wr, bus.m_addr, bus.m_wdata});
        p_wr = bus.m_wr;
        p_addr = bus.m_addr;
        if (bus.m_wr) mem_arr[bus.m_addr] = bus.m_wdata;
        cnt = mem_delay;
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL global_timeout: observed no end of test, expected finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic set_req(input logic ir, input logic [15:0] ia, input logic dr, input logic dw,
                         input logic [15:0] da, input logic [15:0] dd);
    bus.if_req = ir;
    bus.if_addr = ia;
    bus.dm_req = dr;
    bus.dm_wr = dw;
    bus.dm_addr = da;
    bus.dm_wdata = dd;
  endtask
  // called in an idle cycle right after the requests are driven
  task automatic txn(input int delay, output logic g_dm);
    logic wr, seen, tmo;
    logic [15:0] a, wd, rd;
    int start;
    mreq_t m;
    g_dm = bus.dm_req && (!bus.if_req || !last_dm);
    a = g_dm ? bus.dm_addr : bus.if_addr;
    wr = g_dm && bus.dm_wr;
    wd = bus.dm_wdata;
    tmo = delay == 0 || delay > 16;
    start = cyc;
    mem_delay = delay;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = bus.if_done | bus.dm_done;
    end
    check("done_seen", seen, 1);
    check("done_owner", {bus.if_done, bus.dm_done}, g_dm ? 2'b01 : 2'b10);
    check("mreq_count", mlog.size(), 1);
    m = '{-1, 1'bx, 16'hxxxx, 16'hxxxx};
    if (mlog.size() > 0) m = mlog.pop_front();
    check("mreq_cycle", m.c, start + 1);
    check("m_addr", m.a, a);
    check("m_wr", m.wr, wr);
    if (wr) check("m_wdata", m.d, wd);
    check("latency", cyc - m.c, tmo ? 17 : delay + 1);
    rd = (wr || tmo) ? 16'h0 : ref_mem.exists(a) ? ref_mem[a] : a ^ 16'h5A5A;
    if (wr) ref_mem[a] = wd;
    if (tmo) exp_err = 1'b1;
    if (g_dm) exp_dm_rd = rd;
    else exp_if_rd = rd;
    last_dm = g_dm;
    check("if_rdata", bus.if_rdata, exp_if_rd);
    check("dm_rdata", bus.dm_rdata, exp_dm_rd);
    check("err", bus.err, exp_err);
    check("owner_stall", g_dm ? bus.dm_stall : bus.if_stall, 0);
    check("other_stall", g_dm ? bus.if_stall : bus.dm_stall, g_dm ? bus.if_req : bus.dm_req);
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic g, saw;
    int r;
    ref_mem[16'h0010] = 16'h1234;
    last_dm = 1'b0;
    exp_err = 1'b0;
    exp_if_rd = '0;
    exp_dm_rd = '0;
    set_req(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_req", bus.m_req, 0);
    check("rst_dones", {bus.if_done, bus.dm_done}, 0);
    check("rst_m_addr", bus.m_addr, 0);
    check("rst_rdata", {bus.if_rdata, bus.dm_rdata}, 0);
    check("rst_err", bus.err, 0);
    rst = 1'b0;
    set_req(1, 16'h0010, 0, 0, 0, 0);
    txn(1, g);
    check("fetch_data", bus.if_rdata, 16'h1234);
    set_req(0, 0, 1, 1, 16'h0040, 16'hBEEF);
    txn(1, g);
    check("store_rdata", bus.dm_rdata, 0);
    set_req(0, 0, 1, 0, 16'h0040, 0);
    txn(16, g);
    check("coincide_data", bus.dm_rdata, 16'hBEEF);
    check("coincide_err", bus.err, 0);
    set_req(0, 0, 1, 0, 16'h0200, 0);
    txn(0, g);
    check("timeout_err", bus.err, 1);
    set_req(1, 16'h0011, 0, 0, 0, 0);
    txn(2, g);
    set_req(0, 0, 1, 0, 16'h0300, 0);
    mem_delay = 3;
    @(posedge clk);
    #1;
    check("mid_mreq", mlog.size(), 1);
    mlog.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.dm_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    last_dm = 1'b0;
    exp_err = 1'b0;
    exp_if_rd = '0;
    exp_dm_rd = '0;
    check("midrst_outs", {bus.m_req, bus.if_done, bus.dm_done, bus.err}, 0);
    check("midrst_data", {bus.m_addr, bus.if_rdata, bus.dm_rdata}, 0);
    saw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      saw = saw | bus.m_done;
      check("late_quiet", {bus.m_req, bus.if_done, bus.dm_done}, 0);
    end
    check("late_mdone_seen", saw, 1);
    check("late_no_mreq", mlog.size(), 0);
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      set_req(1, 16'h0020 + 16'(k), 1, 0, 16'h0030 + 16'(k), 0);
      txn(1 + k, g);
      check("grant_order", g, (k % 2) == 0);
    end
    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(1, 3);
      set_req(r[0], 16'h0010 + 16'($urandom_range(0, 7)), r[1], 1'($urandom_range(0, 1)),
              16'h0010 + 16'($urandom_range(0, 7)), 16'($urandom));
      txn($urandom_range(1, 6), g);
    end
    set_req(0, 0, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum number of cycles from the m_req pulse to m_done before the transaction is aborted.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 if_req  input  1  fetch request; held until if_done.
REQ-005 if_addr  input  16  fetch address.
REQ-006 dm_req  input  1  data request; held until dm_done.
REQ-007 dm_wr  input  1  1 = store, 0 = load.
REQ-008 dm_addr  input  16  data address.
REQ-009 dm_wdata  input  16  store data.
REQ-010 m_req  output  1  one-cycle start pulse to the shared single-port memory.
REQ-011 m_wr  output  1  write strobe, qualified by m_req.
REQ-012 m_addr  output  16  latched address, stable from the m_req cycle until completion.
REQ-013 m_wdata  output  16  latched store data.
REQ-014 m_done  input  1  memory completion pulse.
REQ-015 m_rdata  input  16  read data, valid when m_done=1.
REQ-016 if_done  output  1  one-cycle fetch completion pulse.
REQ-017 if_rdata  output  16  instruction word; valid when if_done=1.
REQ-018 dm_done  output  1  one-cycle data completion pulse.
REQ-019 dm_rdata  output  16  load data; 0 for stores.
REQ-020 if_stall  output  1  if_req & ~if_done.
REQ-021 dm_stall  output  1  dm_req & ~dm_done.
REQ-022 err  output  1  sticky flag, set on timeout.

Function
REQ-023 The FSM SHALL have four states: IDLE, ISSUE, WAIT and DONE.
REQ-024 IDLE: if any request is present, SHALL latch owner/addr/wr/wdata and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-025 Selection SHALL grant dm when only dm_req is set, if when only if_req is set, and, when both are set, dm unless the previous grant was dm (alternation, no starvation).
REQ-026 ISSUE: m_req=1 for exactly one cycle; SHALL go to WAIT and clear the watchdog counter.
REQ-027 WAIT: on m_done, SHALL capture m_rdata (0 if store) and go to DONE; otherwise SHALL increment the counter.
REQ-028 WAIT: when the counter reaches TIMEOUT with no m_done, SHALL set err, capture 0 and go to DONE.
REQ-029 DONE: the owner's done SHALL be 1 for exactly one cycle with its rdata valid; SHALL then go to IDLE.
REQ-030 Minimum latency SHALL be 3 cycles (req sampled at T0 -> m_req at T1 -> m_done at T2 -> done at T3).
REQ-031 The requester SHALL update its req and address in the cycle after done; in that cycle IDLE SHALL sample the updated values, so back-to-back transactions are 1 idle cycle apart.
REQ-032 m_done in IDLE, ISSUE or DONE SHALL be ignored.
REQ-033 m_done arriving in the same cycle the timeout fires SHALL be treated as a normal completion; err SHALL NOT be set.
REQ-034 if_rdata/dm_rdata SHALL hold their value between done pulses; the non-owner's done SHALL stay 0.
REQ-035 At most one transaction SHALL be outstanding; m_req SHALL never be asserted outside ISSUE.

Reset
REQ-036 rst SHALL force IDLE, counter 0, last-grant to if, err=0, and all outputs to 0 on the next edge, including mid-transaction.
REQ-037 A late m_done after reset SHALL be ignored (IDLE).

Structure
REQ-038 Package mem_arb_pkg SHALL hold the state enum, the owner encoding (OWN_IF, OWN_DM) and the counter width (8 bits).
REQ-039 A single sub-module, arb_watchdog, SHALL hold the clear/increment counter and the expiry compare against TIMEOUT.
REQ-040 Datapath latches SHALL be plain enable registers with no other sub-modules.

Verification
REQ-041 Bench SHALL cover each scenario below.
- if_req=1, addr 0x0010, memory m_done 1 cycle after m_req, data 0x1234 -> m_req at T1, if_done at T3, if_rdata=0x1234.
- dm_req store addr 0x0040 data 0xBEEF -> m_wr=1, m_wdata=0xBEEF, dm_done pulse, dm_rdata=0.
- if_req and dm_req held together for 4 transactions -> grant order dm, if, dm, if.
- Memory never returns m_done, TIMEOUT=15 -> dm_done 17 cycles after m_req, rdata 0, err=1 until rst.
- rst in WAIT, then m_done 2 cycles later -> all outputs 0, no done pulse, FSM in IDLE.
- m_done and timeout expiry in the same cycle -> normal completion, err stays 0.
